// File: rtl/joust2_rom_loader.sv
// joust2_rom_loader: captures the hps_io ROM download, splits the flat image into four
// region RAM write streams and holds the williams2 core in reset until a clean image has landed.
module joust2_rom_loader #(
  parameter logic [7:0]  ROM_INDEX   = 8'd0,
  parameter logic [16:0] R1_BASE     = 17'h0C000,
  parameter logic [16:0] R2_BASE     = 17'h0E000,
  parameter logic [16:0] R3_BASE     = 17'h16000,
  parameter logic [16:0] TOTAL_SIZE  = 17'h18000,
  parameter int          RELEASE_DLY = 16
) (
  input  logic        i_clk_sys,
  input  logic        i_reset_n,
  input  logic        i_ioctl_download,
  input  logic [7:0]  i_ioctl_index,
  input  logic        i_ioctl_wr,
  input  logic [16:0] i_ioctl_addr,
  input  logic [7:0]  i_ioctl_dout,
  output logic        o_ioctl_wait,
  output logic        o_rom_we,
  input  logic        i_rom_ready,
  output logic [1:0]  o_rom_region,
  output logic [16:0] o_rom_addr,
  output logic [7:0]  o_rom_data,
  output logic        o_core_reset_n,
  output logic        o_load_done,
  output logic        o_load_error,
  output logic [15:0] o_checksum
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_RELEASE, S_DONE, S_ERROR} state_t;

  localparam logic [7:0]  REL_LAST   = 8'(RELEASE_DLY - 1);
  localparam logic [17:0] FULL_COUNT = {1'b0, TOTAL_SIZE};

  state_t      r_state, w_state_nx;
  logic        r_dl_q, r_full, r_err_latch, r_wait;
  logic        r_core_reset_n, r_load_done, r_load_error;
  logic [1:0]  r_region;
  logic [16:0] r_addr;
  logic [7:0]  r_data;
  logic [17:0] r_count;
  logic [15:0] r_checksum;
  logic [7:0]  r_rel_cnt;

  logic        w_dl_rise, w_dl_fall, w_start, w_xfer, w_wr_load;
  logic        w_in_range, w_can_cap, w_capture, w_drop;
  logic [1:0]  w_region;
  logic [16:0] w_base;

  assign w_dl_rise  = i_ioctl_download & ~r_dl_q;
  assign w_dl_fall  = ~i_ioctl_download & r_dl_q;
  assign w_start    = w_dl_rise && (i_ioctl_index == ROM_INDEX) &&
                      (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR);
  assign w_xfer     = r_full & i_rom_ready;
  assign w_wr_load  = i_ioctl_wr && (r_state == S_LOAD);
  assign w_in_range = i_ioctl_addr < TOTAL_SIZE;
  // The buffer may refill in the very cycle it hands its byte to the RAM side.
  assign w_can_cap  = ~r_full | w_xfer;
  assign w_capture  = w_wr_load & w_in_range & w_can_cap;
  assign w_drop     = w_wr_load & ~(w_in_range & w_can_cap);

  always_comb begin
    w_region = 2'd3;
    w_base   = R3_BASE;
    if (i_ioctl_addr < R1_BASE) begin
      w_region = 2'd0;
      w_base   = '0;
    end else if (i_ioctl_addr < R2_BASE) begin
      w_region = 2'd1;
      w_base   = R1_BASE;
    end else if (i_ioctl_addr < R3_BASE) begin
      w_region = 2'd2;
      w_base   = R2_BASE;
    end
  end

  always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: if (w_start) w_state_nx = S_LOAD;
      S_LOAD:    if (w_dl_fall) w_state_nx = S_FLUSH;
      S_FLUSH:   if (!r_full)
                   w_state_nx = (r_count == FULL_COUNT && !r_err_latch) ? S_RELEASE : S_ERROR;
      S_RELEASE: if (r_rel_cnt == REL_LAST) w_state_nx = S_DONE;
      default:   w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_full   <= 1'b0;
      r_wait   <= 1'b0;
      r_region <= '0;
      r_addr   <= '0;
      r_data   <= '0;
    end else begin
      r_wait <= r_full & ~i_rom_ready;
      if (w_capture) begin
        r_full   <= 1'b1;
        r_region <= w_region;
        r_addr   <= i_ioctl_addr - w_base;
        r_data   <= i_ioctl_dout;
      end else if (w_xfer) begin
        r_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_dl_q         <= 1'b0;
      r_count        <= '0;
      r_checksum     <= '0;
      r_err_latch    <= 1'b0;
      r_rel_cnt      <= '0;
      r_core_reset_n <= 1'b0;
      r_load_done    <= 1'b0;
      r_load_error   <= 1'b0;
    end else begin
      r_dl_q <= i_ioctl_download;
      if (w_start) begin
        r_count        <= '0;
        r_checksum     <= '0;
        r_err_latch    <= 1'b0;
        r_core_reset_n <= 1'b0;
        r_load_done    <= 1'b0;
        r_load_error   <= 1'b0;
      end else begin
        if (w_xfer) begin
          if (r_count != '1) r_count <= r_count + 18'd1;
          r_checksum <= r_checksum + {8'd0, r_data};
        end
        if (w_drop) r_err_latch <= 1'b1;
        if (r_state == S_RELEASE && w_state_nx == S_DONE) begin
          r_load_done    <= 1'b1;
          r_core_reset_n <= 1'b1;
        end
        if (r_state == S_FLUSH && w_state_nx == S_ERROR) r_load_error <= 1'b1;
      end
      if (r_state == S_RELEASE) r_rel_cnt <= r_rel_cnt + 8'd1;
      else                      r_rel_cnt <= '0;
    end
  end

  assign o_ioctl_wait   = r_wait;
  assign o_rom_we       = r_full;
  assign o_rom_region   = r_region;
  assign o_rom_addr     = r_addr;
  assign o_rom_data     = r_data;
  assign o_core_reset_n = r_core_reset_n;
  assign o_load_done    = r_load_done;
  assign o_load_error   = r_load_error;
  assign o_checksum     = r_checksum;
endmodule
